tv_seq_checker: RTL and testbench
=================================

// Module: tv_seq_checker
// PURPOSE
//  Synthesizable, parametrised successor to the controller test-vector bench.
//  Stores up to DEPTH vectors (stimulus, expected, don't-care mask) loaded over a valid/ready port.
//  Replays them into a DUT at one vector per cycle and checks DUT outputs LAT cycles later under the mask.
//  Reports error count, first failing index/value and pass/fail; used on-board and in sim for controller/datapath blocks.
// PARAMETERS
//  IN_W   25    stimulus width (e.g. {reset,Instr,ALUFlags})
//  OUT_W  16    DUT output / expected / mask width
//  DEPTH  1024  vector memory entries
//  LAT    1     cycles from stim update to dut_out check, 1..8
//  ERR_W  16    err_count width
// PORTS
//  clk            in   1          clock, rising edge
//  reset          in   1          synchronous, active-low
//  load_valid     in   1          vector write request
//  load_ready     out  1          vector write accepted when high
//  load_stim      in   IN_W       stimulus field of vector
//  load_exp       in   OUT_W      expected outputs
//  load_mask      in   OUT_W      1 = compare bit, 0 = don't care
//  start          in   1          begin replay (pulse)
//  clear          in   1          discard vectors, return to IDLE
//  stop_on_err    in   1          sampled at start: halt on first mismatch
//  stim           out  IN_W       registered stimulus to DUT
//  stim_valid     out  1          stim holds a live vector
//  dut_out        in   OUT_W      DUT outputs to check
//  busy           out  1          RUN or DRAIN
//  done           out  1          in DONE
//  pass           out  1          done && err_count==0
//  err_count      out  ERR_W      mismatches, saturating
//  first_err_idx  out  clog2(DEPTH) index of first mismatch
//  first_err_got  out  OUT_W      dut_out at first mismatch
//  vec_count      out  clog2(DEPTH)+1 vectors loaded
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE; all outputs 0; vec_count 0; memory contents undefined.
//  FSM: IDLE -> RUN (start && vec_count>0); RUN -> DRAIN (last vector issued); DRAIN -> DONE (after LAT cycles);
//   DONE -> RUN (start, same vectors); any state -> IDLE on clear (vec_count:=0, stats cleared).
//  Load: load_ready = (state==IDLE) && vec_count<DEPTH; accept writes mem[vec_count], vec_count++.
//   load_valid while !load_ready is dropped, no side effect. start with vec_count==0 is ignored.
//  Start: clears err_count, first_err_*; captures stop_on_err. start while busy is ignored.
//  RUN: cycle k after start, stim=mem[k].stim, stim_valid=1; idx advances 1/cycle, no stalls.
//  Check: exp/mask/idx pipelined LAT stages alongside stim; at stage LAT, mismatch = |((dut_out^exp)&mask).
//   Mismatch: err_count++ (saturates at all-ones); if first, latch first_err_idx/first_err_got.
//  stim holds last vector during DRAIN; stim_valid=0 in DRAIN/DONE/IDLE; stim zeroed in IDLE.
//  stop_on_err: first mismatch -> DONE next cycle; in-flight checks discarded (err_count stays 1).
//  clear and start same cycle: clear wins. clear/reset mid-run abort immediately, no done pulse.
//  done/pass level-held in DONE until start or clear.
// TESTING
//  Load 3 vectors, LAT=1, DUT echoes exp -> done after 3+1 cycles, pass=1, err_count=0.
//  Vector 1 exp=16'h00F0 mask=16'hFFFF, dut_out=16'h00F1 -> err_count=1, first_err_idx=1, first_err_got=16'h00F1.
//  Same mismatch with mask=16'hFFFE -> pass=1 (masked bit ignored).
//  stop_on_err=1, mismatches on vectors 2 and 4 of 6 -> done, err_count=1, first_err_idx=2.
//  Load DEPTH vectors -> load_ready=0 after last; extra load_valid ignored, vec_count==DEPTH.
//  reset low during RUN at vector 5 -> next cycle IDLE, stim_valid=0, vec_count=0, err_count=0.

Source files
------------

// File: rtl/tv_seq_checker.sv
// tv_seq_checker
//   Test-vector sequencer/checker. Vectors {stim, exp, mask} are loaded over a
//   valid/ready port, replayed one per cycle on stim, and dut_out is checked
//   LAT cycles after each stim update under the per-vector don't-care mask.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   load_valid/ready      vector write port; load_stim/exp/mask are the fields
//   start                 begin (or repeat) replay of the loaded vectors
//   clear                 discard vectors and statistics, return to IDLE
//   stop_on_err           sampled at start: end the run on the first mismatch
//   stim, stim_valid      registered stimulus to the DUT and its live flag
//   dut_out               DUT response being checked
//   busy, done, pass      run status (RUN/DRAIN, DONE, DONE without errors)
//   err_count             saturating mismatch count
//   first_err_idx/got     vector index and dut_out of the first mismatch
//   vec_count             number of vectors loaded
//   state_dbg             current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Load handshake: a vector is written on every rising edge where load_valid
// and load_ready are both high. load_ready is high only in IDLE with free
// space; load_valid while load_ready is low is dropped with no side effect.
module tv_seq_checker #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 16,
    parameter int DEPTH = 1024,
    parameter int LAT   = 1,
    parameter int ERR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [IN_W-1:0]          load_stim,
    input  logic [OUT_W-1:0]         load_exp,
    input  logic [OUT_W-1:0]         load_mask,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     stop_on_err,
    output logic [IN_W-1:0]          stim,
    output logic                     stim_valid,
    input  logic [OUT_W-1:0]         dut_out,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_W-1:0]         err_count,
    output logic [$clog2(DEPTH)-1:0] first_err_idx,
    output logic [OUT_W-1:0]         first_err_got,
    output logic [$clog2(DEPTH):0]   vec_count,
    output logic [1:0]               state_dbg
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int VW = IN_W + 2 * OUT_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [VW-1:0]    mem [DEPTH];
    logic [CW-1:0]    rd_idx;
    logic [3:0]       drain_cnt;
    logic             stop_q;

    // Check pipeline: stage 0 is loaded together with stim, stage LAT-1 is
    // compared against dut_out at the following edge.
    logic             p_valid [LAT];
    logic [OUT_W-1:0] p_exp   [LAT];
    logic [OUT_W-1:0] p_mask  [LAT];
    logic [IW-1:0]    p_idx   [LAT];

    logic             load_fire;
    logic             start_ok;
    logic             issue_run;
    logic             mism;
    logic [IW-1:0]    rd_addr;
    logic [VW-1:0]    rd_word;
    logic [IN_W-1:0]  rd_stim;
    logic [OUT_W-1:0] rd_exp;
    logic [OUT_W-1:0] rd_mask;

    assign load_ready = (state == S_IDLE) && (vec_count < CW'(DEPTH));
    assign load_fire  = load_valid && load_ready && !clear;
    // clear beats start; start is only honoured when not busy and vectors exist
    assign start_ok   = start && !clear && (state == S_IDLE || state == S_DONE)
                        && (vec_count != '0);
    assign issue_run  = (state == S_RUN) && (rd_idx != vec_count);
    assign rd_addr    = start_ok ? '0 : rd_idx[IW-1:0];
    assign rd_word    = mem[rd_addr];
    assign rd_stim    = rd_word[VW-1 -: IN_W];
    assign rd_exp     = rd_word[2*OUT_W-1 -: OUT_W];
    assign rd_mask    = rd_word[OUT_W-1:0];
    assign mism       = p_valid[LAT-1]
                        && (((dut_out ^ p_exp[LAT-1]) & p_mask[LAT-1]) != '0);
    assign pass       = done && (err_count == '0);
    assign state_dbg  = state;

    // Vector memory has no reset; entries past vec_count are never read.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[vec_count[IW-1:0]] <= {load_stim, load_exp, load_mask};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state         <= S_IDLE;
            vec_count     <= '0;
            rd_idx        <= '0;
            drain_cnt     <= '0;
            stop_q        <= 1'b0;
            stim          <= '0;
            stim_valid    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            for (int i = 0; i < LAT; i++) begin
                p_valid[i] <= 1'b0;
                p_exp[i]   <= '0;
                p_mask[i]  <= '0;
                p_idx[i]   <= '0;
            end
        end else begin
            if (load_fire) begin
                vec_count <= vec_count + 1'b1;
            end

            for (int i = LAT - 1; i > 0; i--) begin
                p_valid[i] <= p_valid[i-1];
                p_exp[i]   <= p_exp[i-1];
                p_mask[i]  <= p_mask[i-1];
                p_idx[i]   <= p_idx[i-1];
            end
            p_valid[0] <= start_ok || issue_run;
            p_exp[0]   <= rd_exp;
            p_mask[0]  <= rd_mask;
            p_idx[0]   <= rd_addr;

            if (mism) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (err_count == '0) begin
                    first_err_idx <= p_idx[LAT-1];
                    first_err_got <= dut_out;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state         <= S_RUN;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        stop_q        <= stop_on_err;
                        stim          <= rd_stim;
                        stim_valid    <= 1'b1;
                        rd_idx        <= CW'(1);
                        err_count     <= '0;
                        first_err_idx <= '0;
                        first_err_got <= '0;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (stop_q && mism) begin
                        // Halt: stim keeps its last value, later checks are dropped
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        stim_valid <= 1'b0;
                        for (int i = 0; i < LAT; i++) begin
                            p_valid[i] <= 1'b0;
                        end
                    end else if (state == S_RUN) begin
                        if (issue_run) begin
                            stim       <= rd_stim;
                            stim_valid <= 1'b1;
                            rd_idx     <= rd_idx + 1'b1;
                        end else begin
                            state      <= S_DRAIN;
                            stim_valid <= 1'b0;
                            drain_cnt  <= '0;
                        end
                    end else if (drain_cnt == 4'(LAT - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tv_seq_checker.sv
// tb_tv_seq_checker
//   Bench for tv_seq_checker (DEPTH=16, LAT=1). The DUT model is a
//   combinational lookup: the low 4 stim bits select a response from b_resp.
//   Issued stim vectors are checked in order against a scoreboard queue.
module tb_tv_seq_checker;
    localparam int IN_W  = 25;
    localparam int OUT_W = 16;
    localparam int DEPTH = 16;
    localparam int LAT   = 1;
    localparam int ERR_W = 16;
    localparam int IW    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [IN_W-1:0]  load_stim = '0;
    logic [OUT_W-1:0] load_exp = '0;
    logic [OUT_W-1:0] load_mask = '0;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic             stop_on_err = 1'b0;
    logic [IN_W-1:0]  stim;
    logic             stim_valid;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [IW-1:0]    first_err_idx;
    logic [OUT_W-1:0] first_err_got;
    logic [IW:0]      vec_count;
    logic [1:0]       state_dbg;

    logic [IN_W-1:0]  b_stim [DEPTH];
    logic [OUT_W-1:0] b_exp  [DEPTH];
    logic [OUT_W-1:0] b_mask [DEPTH];
    logic [OUT_W-1:0] b_resp [DEPTH];

    logic [IN_W-1:0]  exp_q [$];
    logic [IN_W-1:0]  mon_e;
    bit               mon_en = 1'b0;
    int               n_cmp = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    assign dut_out = b_resp[stim[IW-1:0]];

    tv_seq_checker #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(LAT), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
        .start(start), .clear(clear), .stop_on_err(stop_on_err),
        .stim(stim), .stim_valid(stim_valid), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_got(first_err_got),
        .vec_count(vec_count), .state_dbg(state_dbg)
    );

    // Scoreboard: every live stim must be the next expected vector.
    always @(negedge clk) begin
        if (mon_en && stim_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stim_order: got %h, no vector expected", stim);
            end else begin
                mon_e = exp_q.pop_front();
                if (stim !== mon_e) begin
                    n_fail++;
                    $display("FAIL stim_order: got %h, required %h", stim, mon_e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic load_vec(input logic [IN_W-1:0] s, input logic [OUT_W-1:0] e,
                            input logic [OUT_W-1:0] m);
        load_valid = 1'b1;
        load_stim  = s;
        load_exp   = e;
        load_mask  = m;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic prep(input int n);
        for (int i = 0; i < n; i++) begin
            b_stim[i] = {21'($urandom), 4'(i)};
            b_exp[i]  = 16'($urandom_range(0, 65535));
            b_mask[i] = 16'hFFFF;
            b_resp[i] = b_exp[i];
        end
    endtask

    task automatic load_set(input int n);
        for (int i = 0; i < n; i++) load_vec(b_stim[i], b_exp[i], b_mask[i]);
    endtask

    task automatic run_vectors(input int n, input bit stop, output int cycles);
        if (mon_en) for (int i = 0; i < n; i++) exp_q.push_back(b_stim[i]);
        stop_on_err = stop;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL run_timeout: done=%b after %0d cycles, required 1", done, cycles);
        end
        if (mon_en) begin
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL stim_count: %0d vectors never issued, required 0", exp_q.size());
            end
            exp_q.delete();
        end
    endtask

    // Reference: mismatch statistics over the loaded table.
    task automatic model(input int n, input bit stop, output int errs, output int fidx,
                         output logic [OUT_W-1:0] fgot);
        errs = 0;
        fidx = 0;
        fgot = '0;
        for (int i = 0; i < n; i++) begin
            if (((b_resp[i] ^ b_exp[i]) & b_mask[i]) != 16'h0) begin
                if (errs == 0) begin
                    fidx = i;
                    fgot = b_resp[i];
                end
                errs++;
                if (stop) break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d, required 0", state_dbg); end
        n_cmp++; if (stim !== '0 || stim_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stim: got %h/%b, required 0/0", stim, stim_valid); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("FAIL rst_status: got %b%b%b, required 000", busy, done, pass); end
        n_cmp++; if (err_count !== '0 || first_err_idx !== '0 || first_err_got !== '0) begin n_fail++; $display("FAIL rst_stats: got %0d/%0d/%h, required 0/0/0", err_count, first_err_idx, first_err_got); end
        n_cmp++; if (vec_count !== '0 || load_ready !== 1'b1) begin n_fail++; $display("FAIL rst_load: got vec_count=%0d ready=%b, required 0/1", vec_count, load_ready); end
    endtask

    task automatic test_basic_pass();
        int cyc;
        prep(3);
        load_set(3);
        n_cmp++; if (vec_count !== 5'd3) begin n_fail++; $display("FAIL basic_vec_count: got %0d, required 3", vec_count); end
        mon_en = 1'b1;
        run_vectors(3, 1'b0, cyc);
        n_cmp++; if (cyc !== 3 + LAT) begin n_fail++; $display("FAIL basic_latency: got %0d, required %0d", cyc, 3 + LAT); end
        n_cmp++; if (pass !== 1'b1 || err_count !== '0) begin n_fail++; $display("FAIL basic_pass: got pass=%b err=%0d, required 1/0", pass, err_count); end
        n_cmp++; if (busy !== 1'b0 || state_dbg !== 2'd3) begin n_fail++; $display("FAIL basic_done_state: got busy=%b state=%0d, required 0/3", busy, state_dbg); end
        n_cmp++; if (stim !== b_stim[2] || stim_valid !== 1'b0) begin n_fail++; $display("FAIL basic_stim_hold: got %h/%b, required %h/0", stim, stim_valid, b_stim[2]); end
    endtask

    task automatic test_mismatch();
        int cyc;
        do_clear();
        n_cmp++; if (vec_count !== '0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL clr_state: got vec=%0d state=%0d, required 0/0", vec_count, state_dbg); end
        prep(3);
        b_exp[1] = 16'h00F0;
        b_resp[1] = 16'h00F1;
        load_set(3);
        run_vectors(3, 1'b0, cyc);
        n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL mis_err: got %0d, required 1", err_count); end
        n_cmp++; if (first_err_idx !== 4'd1 || first_err_got !== 16'h00F1) begin n_fail++; $display("FAIL mis_first: got %0d/%h, required 1/00f1", first_err_idx, first_err_got); end
        n_cmp++; if (pass !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL mis_pass: got pass=%b done=%b, required 0/1", pass, done); end
        // loads outside IDLE are dropped
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL done_ready: got %b, required 0", load_ready); end
        load_vec('1, 16'h1234, 16'hFFFF);
        n_cmp++; if (vec_count !== 5'd3) begin n_fail++; $display("FAIL done_load_drop: got %0d, required 3", vec_count); end
        // restart from DONE recomputes statistics from zero
        run_vectors(3, 1'b0, cyc);
        n_cmp++; if (err_count !== 16'd1 || first_err_idx !== 4'd1) begin n_fail++; $display("FAIL restart_err: got %0d/%0d, required 1/1", err_count, first_err_idx); end
    endtask

    task automatic test_masked();
        int cyc;
        do_clear();
        prep(3);
        b_exp[1] = 16'h00F0;
        b_mask[1] = 16'hFFFE;
        b_resp[1] = 16'h00F1;
        load_set(3);
        run_vectors(3, 1'b0, cyc);
        n_cmp++; if (pass !== 1'b1 || err_count !== '0) begin n_fail++; $display("FAIL masked_pass: got pass=%b err=%0d, required 1/0", pass, err_count); end
    endtask

    task automatic test_stop_on_err();
        int cyc;
        do_clear();
        prep(6);
        b_resp[2] = b_exp[2] ^ 16'h0100;
        b_resp[4] = b_exp[4] ^ 16'h0001;
        load_set(6);
        mon_en = 1'b0;
        run_vectors(6, 1'b1, cyc);
        n_cmp++; if (err_count !== 16'd1 || first_err_idx !== 4'd2) begin n_fail++; $display("FAIL stop_err: got %0d/%0d, required 1/2", err_count, first_err_idx); end
        n_cmp++; if (first_err_got !== b_resp[2] || pass !== 1'b0) begin n_fail++; $display("FAIL stop_got: got %h pass=%b, required %h/0", first_err_got, pass, b_resp[2]); end
        mon_en = 1'b1;
        run_vectors(6, 1'b0, cyc);
        n_cmp++; if (err_count !== 16'd2 || first_err_idx !== 4'd2) begin n_fail++; $display("FAIL nostop_err: got %0d/%0d, required 2/2", err_count, first_err_idx); end
    endtask

    task automatic test_random();
        int cyc, errs, fidx;
        logic [OUT_W-1:0] fgot;
        for (int r = 0; r < 3; r++) begin
            do_clear();
            prep(12);
            for (int i = 0; i < 12; i++) begin
                b_mask[i] = 16'($urandom_range(0, 65535));
                if ($urandom_range(0, 2) == 0) b_resp[i] = b_exp[i] ^ 16'($urandom_range(1, 65535));
            end
            model(12, 1'b0, errs, fidx, fgot);
            load_set(12);
            run_vectors(12, 1'b0, cyc);
            n_cmp++; if (err_count !== 16'(errs)) begin n_fail++; $display("FAIL rand_err: got %0d, required %0d", err_count, errs); end
            n_cmp++; if (first_err_idx !== 4'(fidx) || first_err_got !== fgot) begin n_fail++; $display("FAIL rand_first: got %0d/%h, required %0d/%h", first_err_idx, first_err_got, fidx, fgot); end
            n_cmp++; if (pass !== (errs == 0)) begin n_fail++; $display("FAIL rand_pass: got %b, required %b", pass, errs == 0); end
        end
    endtask

    task automatic test_full_load();
        int cyc;
        do_clear();
        prep(DEPTH);
        load_set(DEPTH - 1);
        n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_before: got %b, required 1", load_ready); end
        load_vec(b_stim[DEPTH-1], b_exp[DEPTH-1], b_mask[DEPTH-1]);
        n_cmp++; if (load_ready !== 1'b0 || vec_count !== 5'(DEPTH)) begin n_fail++; $display("FAIL full_ready_after: got ready=%b vec=%0d, required 0/%0d", load_ready, vec_count, DEPTH); end
        load_vec('0, 16'hDEAD, 16'hFFFF);
        n_cmp++; if (vec_count !== 5'(DEPTH)) begin n_fail++; $display("FAIL full_extra_drop: got %0d, required %0d", vec_count, DEPTH); end
        run_vectors(DEPTH, 1'b0, cyc);
        n_cmp++; if (cyc !== DEPTH + LAT || pass !== 1'b1) begin n_fail++; $display("FAIL full_run: got cyc=%0d pass=%b, required %0d/1", cyc, pass, DEPTH + LAT); end
    endtask

    task automatic test_start_empty();
        do_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (state_dbg !== 2'd0 || busy !== 1'b0 || stim_valid !== 1'b0) begin n_fail++; $display("FAIL empty_start: got state=%0d busy=%b sv=%b, required 0/0/0", state_dbg, busy, stim_valid); end
    endtask

    task automatic test_clear_priority();
        int cyc;
        do_clear();
        prep(3);
        b_resp[0] = b_exp[0] ^ 16'h8000;
        load_set(3);
        run_vectors(3, 1'b0, cyc);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        n_cmp++; if (state_dbg !== 2'd0 || vec_count !== '0 || done !== 1'b0) begin n_fail++; $display("FAIL clr_start: got state=%0d vec=%0d done=%b, required 0/0/0", state_dbg, vec_count, done); end
        n_cmp++; if (err_count !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_start_stats: got err=%0d busy=%b, required 0/0", err_count, busy); end
    endtask

    task automatic test_abort();
        int w;
        mon_en = 1'b0;
        // reset mid-run
        do_clear();
        prep(8);
        b_resp[1] = b_exp[1] ^ 16'h0010;
        load_set(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!(stim_valid === 1'b1 && stim === b_stim[5]) && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_cmp++; if (w >= 50) begin n_fail++; $display("FAIL abort_wait: vector 5 not seen in %0d cycles, required <50", w); end
        n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL abort_pre_err: got %0d, required 1", err_count); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_cmp++; if (state_dbg !== 2'd0 || stim_valid !== 1'b0 || vec_count !== '0) begin n_fail++; $display("FAIL rst_abort: got state=%0d sv=%b vec=%0d, required 0/0/0", state_dbg, stim_valid, vec_count); end
        n_cmp++; if (err_count !== '0 || done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_abort_stats: got err=%0d done=%b busy=%b, required 0/0/0", err_count, done, busy); end
        // clear mid-run
        prep(8);
        load_set(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b1 || state_dbg !== 2'd1) begin n_fail++; $display("FAIL run_busy: got busy=%b state=%0d, required 1/1", busy, state_dbg); end
        do_clear();
        n_cmp++; if (state_dbg !== 2'd0 || done !== 1'b0 || stim !== '0 || stim_valid !== 1'b0) begin n_fail++; $display("FAIL clr_abort: got state=%0d done=%b stim=%h sv=%b, required 0/0/0/0", state_dbg, done, stim, stim_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_pass();
        test_mismatch();
        test_masked();
        test_stop_on_err();
        test_random();
        test_full_load();
        test_start_empty();
        test_clear_priority();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
